// File: rtl/pll_rst_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
// Pure declarations: no logic, no latency.
package pll_rst_seq_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN
    } state_t;

    localparam int LOSS_CNT_W = 8;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Purpose: multi-flop synchroniser for a single asynchronous level.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; samples every cycle.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Purpose: pulse PLL reset, qualify lock, release stage resets in order; macro PLL_LOCK_TIMEOUT_EN adds a lock-wait timeout.
// Latency: outputs registered; lock changes act SYNC_STAGES+1 cycles after the pin moves.
// Backpressure: none; free-running sequencer with no flow control.
module pll_reset_sequencer
    import pll_rst_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int NUM_STAGES         = 3,
    parameter int STAGE_GAP          = 8,
    parameter int SYNC_STAGES        = 2,
    parameter int TIMEOUT_CYCLES     = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  all_ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int CNT_MAX = max_int(max_int(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                     max_int(STAGE_GAP, TIMEOUT_EN ? TIMEOUT_CYCLES : 1));
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int IDX_W   = cnt_width(NUM_STAGES);

    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees lock is the first cycle of the window.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_STAGES - 1);
`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    logic locked_s;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pll_rst_q, pll_rst_d;
    logic [NUM_STAGES-1:0]   stage_rst_q, stage_rst_d;
    logic                    all_ready_q, all_ready_d;
    logic [LOSS_CNT_W-1:0]   loss_q, loss_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            idx_q       <= '0;
            pll_rst_q   <= 1'b1;
            stage_rst_q <= '1;
            all_ready_q <= 1'b0;
            loss_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pll_rst_q   <= pll_rst_d;
            stage_rst_q <= stage_rst_d;
            all_ready_q <= all_ready_d;
            loss_q      <= loss_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        pll_rst_d   = pll_rst_q;
        stage_rst_d = stage_rst_q;
        all_ready_d = all_ready_q;
        loss_d      = loss_q;

        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == PLL_LAST) begin
                    state_d   = S_WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_LOCK: begin
                if (locked_s) begin
                    cnt_d = '0;
                    if (LOCK_STABLE_CYCLES == 1) begin
                        state_d     = S_RELEASE;
                        idx_d       = '0;
                        stage_rst_d = stage_rst_q << 1;
                    end else begin
                        state_d = S_STABLE;
                    end
                end
`ifdef PLL_LOCK_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d   = S_PLL_RST;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d     = S_RELEASE;
                    cnt_d       = '0;
                    idx_d       = '0;
                    stage_rst_d = stage_rst_q << 1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RELEASE, S_RUN: begin
                // Lock loss wins over any release due in the same cycle.
                if (!locked_s) begin
                    state_d     = S_PLL_RST;
                    cnt_d       = '0;
                    idx_d       = '0;
                    pll_rst_d   = 1'b1;
                    stage_rst_d = '1;
                    all_ready_d = 1'b0;
                    if (loss_q != {LOSS_CNT_W{1'b1}}) begin
                        loss_d = loss_q + LOSS_CNT_W'(1);
                    end
                end else if (state_q == S_RELEASE) begin
                    if (idx_q == IDX_LAST) begin
                        state_d     = S_RUN;
                        all_ready_d = 1'b1;
                    end else if (cnt_q == GAP_LAST) begin
                        cnt_d       = '0;
                        idx_d       = idx_q + IDX_W'(1);
                        stage_rst_d = stage_rst_q << 1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_PLL_RST;
            end
        endcase
    end

    assign pll_rst         = pll_rst_q;
    assign stage_rst       = stage_rst_q;
    assign all_ready       = all_ready_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus randomized lock traffic
// checked every cycle against a timestamp-based model of the sequencing rules.
module tb_pll_reset_sequencer;

    localparam int PLL  = 4;
    localparam int STB  = 8;
    localparam int NS   = 3;
    localparam int GAP  = 2;
    localparam int SYNC = 2;
    localparam int TO   = 32;

    logic          clk;
    logic          rst;
    logic          pll_locked;
    logic          pll_rst;
    logic [NS-1:0] stage_rst;
    logic          all_ready;
    logic [7:0]    lock_loss_count;

    int checks;
    int errors;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (PLL),
        .LOCK_STABLE_CYCLES (STB),
        .NUM_STAGES         (NS),
        .STAGE_GAP          (GAP),
        .SYNC_STAGES        (SYNC),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .stage_rst       (stage_rst),
        .all_ready       (all_ready),
        .lock_loss_count (lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state as edge timestamps: when PLL reset ends, when the current
    // lock run began, when stage 0 was released, when lock-waiting began.
    int         m_e;
    int         m_pll_end;
    int         m_wait;
    int         m_run;
    int         m_rel;
    logic [7:0] m_loss;
    logic       m_q[$];

    task automatic model_edge(input logic r, input logic pin);
        logic l;
        m_e++;
        if (r) begin
            m_pll_end = m_e + PLL;
            m_wait    = m_pll_end;
            m_run     = -1;
            m_rel     = -1;
            m_loss    = 8'd0;
            m_q.delete();
            for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
            return;
        end
        l = m_q.pop_front();
        m_q.push_back(pin);
        if (m_rel >= 0) begin
            if (!l) begin
                if (m_loss != 8'd255) m_loss = m_loss + 8'd1;
                m_pll_end = m_e + PLL;
                m_wait    = m_pll_end;
                m_rel     = -1;
                m_run     = -1;
            end
        end else if (m_e > m_pll_end) begin
            if (l) begin
                if (m_run < 0) m_run = m_e;
                if (m_e - m_run + 1 >= STB) m_rel = m_e;
            end else if (m_run >= 0) begin
                m_run  = -1;
                m_wait = m_e;
            end
`ifdef PLL_LOCK_TIMEOUT_EN
            else if (m_e - m_wait >= TO) begin
                m_pll_end = m_e + PLL;
                m_wait    = m_pll_end;
            end
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, m_e);
        end
    endtask

    task automatic check_outputs();
        logic [NS-1:0] exp_stage;
        for (int k = 0; k < NS; k++)
            exp_stage[k] = !(m_rel >= 0 && m_e >= m_rel + k * GAP);
        chk("model pll_rst", pll_rst, (m_rel < 0) && (m_e < m_pll_end));
        chk("model stage_rst", stage_rst, exp_stage);
        chk("model all_ready", all_ready, m_rel >= 0 && m_e >= m_rel + (NS - 1) * GAP + 1);
        chk("model lock_loss_count", lock_loss_count, m_loss);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(rst, pll_locked);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic reset_pulse(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int rises;
        logic prev;
        checks     = 0;
        errors     = 0;
        m_e        = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;
        @(negedge clk);

        // Reset values
        reset_pulse(3);
        chk("reset pll_rst", pll_rst, 1'b1);
        chk("reset stage_rst", stage_rst, 3'b111);
        chk("reset all_ready", all_ready, 1'b0);
        chk("reset lock_loss_count", lock_loss_count, 8'd0);

        // Lock glitch inside the stability window restarts the window
        n = 0;
        do begin tick(); n++; end while (pll_rst !== 1'b0 && n < 30);
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        chk("glitch stage_rst held", stage_rst, 3'b111);
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (stage_rst[0] !== 1'b0 && n < 50);
        chk("glitch window restart", n, SYNC + STB);
        chk("glitch no loss counted", lock_loss_count, 8'd0);

        // Clean bring-up: lock at t10
        pll_locked = 1'b0;
        reset_pulse(1);
        n = 0;
        do begin tick(); n++; end while (pll_rst !== 1'b0 && n < 30);
        chk("pll_rst episode length", n, PLL);
        repeat (10 - PLL) tick();
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (stage_rst[0] !== 1'b0 && n < 50);
        chk("stage0 release delay", n, SYNC + STB);
        n = 0;
        do begin tick(); n++; end while (stage_rst[1] !== 1'b0 && n < 50);
        chk("stage1 gap", n, GAP);
        n = 0;
        do begin tick(); n++; end while (stage_rst[2] !== 1'b0 && n < 50);
        chk("stage2 gap", n, GAP);
        n = 0;
        do begin tick(); n++; end while (all_ready !== 1'b1 && n < 50);
        chk("all_ready delay", n, 1);

        // Lock loss in S_RUN: pin -> synchroniser -> FSM edge
        repeat (5) tick();
        pll_locked = 1'b0;
        n = 0;
        do begin tick(); n++; end while (stage_rst !== 3'b111 && n < 20);
        chk("loss reaction delay", n, SYNC + 1);
        chk("loss pll_rst", pll_rst, 1'b1);
        chk("loss all_ready", all_ready, 1'b0);
        chk("loss count one", lock_loss_count, 8'd1);
        n = 0;
        do begin tick(); n++; end while (pll_rst !== 1'b0 && n < 30);
        chk("loss pll_rst episode", n, PLL);
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (all_ready !== 1'b1 && n < 100);
        chk("relock all_ready", all_ready, 1'b1);

        // Lock drop seen on the same edge stage 1 would release
        pll_locked = 1'b0;
        repeat (10) tick();
        chk("pre-drop count", lock_loss_count, 8'd2);
        pll_locked = 1'b1;
        repeat (SYNC + STB - 1) tick();
        pll_locked = 1'b0;
        tick();
        chk("drop stage0 released", stage_rst, 3'b110);
        n = 0;
        repeat (12) begin
            tick();
            if (stage_rst[1] === 1'b0) n++;
        end
        chk("stage1 never released", n, 0);
        chk("drop stage_rst all", stage_rst, 3'b111);
        chk("drop count", lock_loss_count, 8'd3);

        // Lock held low: timeout re-pulses only when enabled
        rises = 0;
        prev  = pll_rst;
        repeat (120) begin
            tick();
            if (pll_rst === 1'b1 && prev === 1'b0) rises++;
            prev = pll_rst;
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        chk("timeout pulse count", (rises >= 3 && rises <= 4), 1'b1);
`else
        chk("no timeout pulses", rises, 0);
`endif
        chk("timeout count unchanged", lock_loss_count, 8'd3);

        // Randomized lock traffic with occasional resets
        repeat (150) begin
            pll_locked = 1'b1;
            repeat ($urandom_range(1, 40)) tick();
            pll_locked = 1'b0;
            repeat ($urandom_range(1, 6)) tick();
            if ($urandom_range(0, 40) == 0) reset_pulse(1);
        end

        // Saturation of the loss counter
        pll_locked = 1'b0;
        reset_pulse(1);
        repeat (261) begin
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            repeat (14 + $urandom_range(0, 6)) tick();
        end
        chk("loss count saturated", lock_loss_count, 8'd255);

        // Reset in the middle of the release sequence
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (stage_rst !== 3'b110 && n < 60);
        chk("mid-release reached", stage_rst, 3'b110);
        reset_pulse(1);
        chk("mid-release rst pll_rst", pll_rst, 1'b1);
        chk("mid-release rst stage_rst", stage_rst, 3'b111);
        chk("mid-release rst all_ready", all_ready, 1'b0);
        chk("mid-release rst count", lock_loss_count, 8'd0);
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
